// File: rtl/icache_plru_replacer.sv
// Tree pseudo-LRU victim selector for an 8-way instruction cache.
// Holds one 7-bit tree per set. It returns the victim way for the presented set
// combinationally and updates the tree on every touch, flush or reset.

// Generic W-bit register with write enable and synchronous active-low reset.
module icache_plru_en_reg #(
  parameter int            W  = 7,
  parameter logic [W-1:0]  RV = '0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  // Reset has priority over the write enable.
  always_ff @(posedge clock) begin
    if (!reset)  q <= RV;
    else if (en) q <= d;
  end
endmodule

module icache_plru_replacer #(
  parameter int NSET  = 32,
  parameter int NWAY  = 8,
  parameter int IDX_W = 5,
  parameter int WAY_W = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [IDX_W-1:0] idx,
  input  logic [WAY_W-1:0] way,
  input  logic             access,
  input  logic             invalid,
  input  logic             flush,
  output logic [WAY_W-1:0] rway_o
);
  localparam int TREE_W = NWAY - 1;

  // Bit b0 is the root, b1 and b2 are the half nodes, and b3..b6 are the leaf pairs.
  // A bit value of 1 means the victim is in the upper subtree.
  logic [NSET-1:0][TREE_W-1:0] tree;
  logic [TREE_W-1:0]           cur, nxt;
  logic                        touch;

  // Walk from the root toward the less recently used side.
  function automatic logic [WAY_W-1:0] plru_victim(input logic [TREE_W-1:0] t);
    logic r2, r1, r0;
    r2 = t[0];
    r1 = r2 ? t[2] : t[1];
    case ({r2, r1})
      2'b00:   r0 = t[3];
      2'b01:   r0 = t[4];
      2'b10:   r0 = t[5];
      default: r0 = t[6];
    endcase
    return {r2, r1, r0};
  endfunction

  // Point every node on the path to w away from w. Nodes off that path keep their value.
  function automatic logic [TREE_W-1:0] plru_touch(input logic [TREE_W-1:0] t,
                                                   input logic [WAY_W-1:0]  w);
    logic [TREE_W-1:0] n;
    n    = t;
    n[0] = ~w[2];
    if (w[2]) n[2] = ~w[1];
    else      n[1] = ~w[1];
    case (w[2:1])
      2'b00:   n[3] = ~w[0];
      2'b01:   n[4] = ~w[0];
      2'b10:   n[5] = ~w[0];
      default: n[6] = ~w[0];
    endcase
    return n;
  endfunction

  assign cur    = tree[idx];
  assign touch  = access | invalid;
  assign rway_o = plru_victim(cur);

  // One next-value path serves all sets. A flush writes zeros into every set.
  // A touch writes only the set selected by idx.
  always_comb begin
    nxt = '0;
    if (!flush) nxt = plru_touch(cur, way);
  end

  for (genvar s = 0; s < NSET; s++) begin : g_set
    logic wen;
    assign wen = flush | (touch && (idx == IDX_W'(s)));
    icache_plru_en_reg #(.W(TREE_W), .RV('0)) u_tree (
      .clock (clock),
      .reset (reset),
      .en    (wen),
      .d     (nxt),
      .q     (tree[s])
    );
  end
endmodule

// File: tb/tb_icache_plru_replacer.sv
// Scoreboard bench for icache_plru_replacer.
// The reference keeps a last-touch timestamp for every way in every set.
// It derives the victim by repeatedly choosing the half that does not hold the most recent touch.
module tb_icache_plru_replacer;
  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] idx = '0;
  logic [2:0] way = '0;
  logic       access = 1'b0, invalid = 1'b0, flush = 1'b0;
  logic [2:0] rway_o;

  int         passed = 0;
  int         total  = 0;
  logic [2:0] expq[$];
  string      nameq[$];

  int unsigned ts[32][8];
  int unsigned stamp = 0;

  icache_plru_replacer dut (
    .clock(clock), .reset(reset), .idx(idx), .way(way),
    .access(access), .invalid(invalid), .flush(flush), .rway_o(rway_o)
  );

  always #5 clock = ~clock;

  function automatic void m_clear();
    foreach (ts[s, w]) ts[s][w] = 0;
  endfunction

  // Return the most recently touched way in [lo, lo+n), or -1 if none was touched.
  function automatic int m_newest(input int s, input int lo, input int n);
    int best = -1;
    int unsigned bt = 0;
    for (int w = lo; w < lo + n; w++)
      if (ts[s][w] > bt) begin bt = ts[s][w]; best = w; end
    return best;
  endfunction

  function automatic logic [2:0] m_victim(input int s);
    int b, h, q, l;
    b = m_newest(s, 0, 8);          h = (b < 0) ? 0 : 1 - b / 4;
    b = m_newest(s, 4 * h, 4);      q = (b < 0) ? 0 : 1 - (b / 2) % 2;
    b = m_newest(s, 4 * h + 2 * q, 2); l = (b < 0) ? 0 : 1 - b % 2;
    return 3'(4 * h + 2 * q + l);
  endfunction

  // Drive one cycle and queue the value rway_o must show during that cycle.
  // The model is updated afterwards, because the edge at the end of the cycle applies the update.
  task automatic step(input string nm, input logic [4:0] i, input logic [2:0] w,
                      input logic a, input logic v, input logic f, input logic r);
    @(posedge clock); #1;
    idx = i; way = w; access = a; invalid = v; flush = f; reset = r;
    expq.push_back(m_victim(int'(i)));
    nameq.push_back(nm);
    if (!r || f) m_clear();
    else if (a || v) begin stamp++; ts[i][w] = stamp; end
  endtask

  task automatic sweep(input string nm);
    for (int s = 0; s < 32; s++) step(nm, 5'(s), 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // Monitor: the output is live every cycle, so check one queued expectation per cycle.
  always @(negedge clock) begin
    if (expq.size() > 0) begin
      logic [2:0] e;
      string      n;
      e = expq.pop_front();
      n = nameq.pop_front();
      total++;
      if (rway_o !== e)
        $display("FAIL %s t=%0t idx=%0d rway_o=%0d expected=%0d", n, $time, idx, rway_o, e);
      else
        passed++;
    end
  end

  initial begin
    logic [2:0] v;
    m_clear();
    // Hold reset low for two edges before checking, so the registers are defined.
    repeat (2) @(posedge clock);
    step("reset_hold", 5'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("reset_hold", 5'd17, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    sweep("reset_sweep");

    // Chase the victim in set 3: 0,4,2,6,1,5,3,7,0.
    for (int k = 0; k < 9; k++) begin
      v = m_victim(3);
      step("chase_set3", 5'd3, v, 1'b1, 1'b0, 1'b0, 1'b1);
    end
    step("chase_set3", 5'd3, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);

    // A touch must affect only its own set.
    step("iso_touch", 5'd5, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    step("iso_set6", 5'd6, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step("iso_set5", 5'd5, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);

    // A flush wins over a simultaneous access.
    step("flush_pre", 5'd7, 3'd4, 1'b1, 1'b0, 1'b0, 1'b1);
    step("flush_pre", 5'd7, 3'd2, 1'b1, 1'b0, 1'b0, 1'b1);
    step("flush_pre", 5'd7, 3'd6, 1'b1, 1'b0, 1'b0, 1'b1);
    step("flush_acc", 5'd7, 3'd1, 1'b1, 1'b0, 1'b1, 1'b1);
    sweep("flush_sweep");

    // An invalid pulse alone counts as a touch.
    step("inval9", 5'd9, 3'd3, 1'b0, 1'b1, 1'b0, 1'b1);
    step("inval9_rd", 5'd9, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step("both9", 5'd9, 3'd5, 1'b1, 1'b1, 1'b0, 1'b1);
    step("both9_rd", 5'd9, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset in the middle of activity overrides an access in the same cycle.
    for (int k = 0; k < 6; k++)
      step("pre_rst", 5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)), 1'b1, 1'b0, 1'b0, 1'b1);
    step("rst_acc", 5'd12, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    sweep("rst_sweep");

    // Random traffic. Indices are concentrated on a few sets so the trees fill up.
    for (int k = 0; k < 3000; k++) begin
      logic [4:0] ri;
      ri = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
      step("random", ri, 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 9) < 4), 1'($urandom_range(0, 9) == 0),
           1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 299) != 0));
    end

    @(posedge clock); #1;
    reset = 1'b1; access = 1'b0; invalid = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clock);
    total++;
    if (expq.size() != 0)
      $display("FAIL drain pending=%0d expected=0", expq.size());
    else
      passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
